// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier: a rising edge of start in IDLE
// captures a and b, WIDTH iterations later product updates with a one-cycle done.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clock_100Mhz,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic               start_rise;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_shifted;

  // Request/acknowledge: start is a level and only a 0->1 transition seen in
  // IDLE is accepted; done pulses once when product takes the new result.
  assign start_rise = start & ~start_q;

  always_comb begin
    state_d     = state_q;
    start_d     = start;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    count_d     = count_q;
    product_d   = product_q;
    addend      = mplier_q[0] ? mcand_q : '0;
    sum         = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    // The carry out of the upper-half add becomes the new MSB after the shift.
    acc_shifted = (2*WIDTH)'({sum, acc_q[WIDTH-1:0]} >> 1);

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_shifted;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          product_d = acc_shifted;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b1;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: WIDTH=4 and WIDTH=8 instances, expected products
// queued when a start is driven and popped when done is observed.
module tb_seq_multiplier;

  logic        clock_100Mhz = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  a, b;
  logic [7:0]  product;
  logic        busy, done;

  logic        start8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;
  logic        busy8, done8;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] exp8_q[$];

  int corner_a[4] = '{15, 0, 15, 8};
  int corner_b[4] = '{15, 9, 1, 2};

  // ---------------- clock / reset ----------------
  always #5 clock_100Mhz = ~clock_100Mhz;

  seq_multiplier #(.WIDTH(4)) u_dut (
    .clock_100Mhz(clock_100Mhz),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .product     (product),
    .busy        (busy),
    .done        (done)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clock_100Mhz(clock_100Mhz),
    .reset       (reset),
    .start       (start8),
    .a           (a8),
    .b           (b8),
    .product     (product8),
    .busy        (busy8),
    .done        (done8)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    logic quiet;
    reset  = 1'b1;
    start8 = 1'b0;
    a8     = 8'd0;
    b8     = 8'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock_100Mhz);
      a     = 4'($urandom_range(0, 15));
      b     = 4'($urandom_range(0, 15));
      start = 1'($urandom_range(0, 1));
    end
    @(negedge clock_100Mhz);
    n_checks++;
    if (product !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: product=%0d busy=%b done=%b, required 0/0/0", product, busy, done);
    end
    n_checks++;
    if (product8 !== 16'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state_w8: product=%0d busy=%b done=%b, required 0/0/0", product8, busy8, done8);
    end
    start = 1'b1;
    reset = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock_100Mhz);
      if (busy !== 1'b0 || done !== 1'b0 || product !== 8'd0) quiet = 1'b0;
    end
    n_checks++;
    if (quiet !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_start_high: activity observed=%b, required none", ~quiet);
    end
    start = 1'b0;
    @(negedge clock_100Mhz);
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    a = 4'd13;
    b = 4'd11;
    start = 1'b1;
    exp_q.push_back(8'd143);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock_100Mhz);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_errors++;
        $display("FAIL basic_busy cycle %0d: busy=%b done=%b, required busy=1 done=0", k, busy, done);
      end
    end
    @(negedge clock_100Mhz);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'bx;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_done: done=%b busy=%b, required done=1 busy=0", done, busy);
    end
    n_checks++;
    if (product !== exp) begin
      n_errors++;
      $display("FAIL basic_product: got %0d, required %0d", product, exp);
    end
    @(negedge clock_100Mhz);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 8'd143) begin
      n_errors++;
      $display("FAIL basic_after: done=%b busy=%b product=%0d, required 0/0/143", done, busy, product);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_100Mhz);
      a = 4'(corner_a[i]);
      b = 4'(corner_b[i]);
      start = 1'b1;
      exp_q.push_back(8'(corner_a[i] * corner_b[i]));
      for (int k = 1; k <= 4; k++) begin
        @(negedge clock_100Mhz);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_errors++;
          $display("FAIL corner%0d_busy cycle %0d: busy=%b done=%b, required 1/0", i, k, busy, done);
        end
      end
      @(negedge clock_100Mhz);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'bx;
      n_checks++;
      if (done !== 1'b1 || product !== exp) begin
        n_errors++;
        $display("FAIL corner%0d_result: done=%b product=%0d, required done=1 product=%0d", i, done, product, exp);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    logic [7:0] exp;
    logic [7:0] prod_seen;
    int         done_cnt;
    logic       late_busy;
    done_cnt  = 0;
    late_busy = 1'b0;
    prod_seen = 8'bx;
    @(negedge clock_100Mhz);
    a = 4'd6;
    b = 4'd7;
    start = 1'b1;
    exp_q.push_back(8'd42);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clock_100Mhz);
      case (k)
        1: begin a = 4'd15; b = 4'd15; start = 1'b0; end
        2: start = 1'b1;
        3: start = 1'b0;
        4: start = 1'b1;
        default: ;
      endcase
      if (done === 1'b1) begin
        done_cnt++;
        prod_seen = product;
      end
      if (k > 5 && busy !== 1'b0) late_busy = 1'b1;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'bx;
    n_checks++;
    if (done_cnt != 1) begin
      n_errors++;
      $display("FAIL ignored_done_count: got %0d pulses, required 1", done_cnt);
    end
    n_checks++;
    if (prod_seen !== exp) begin
      n_errors++;
      $display("FAIL ignored_product: got %0d, required %0d", prod_seen, exp);
    end
    n_checks++;
    if (late_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ignored_retrigger: busy seen=%b while start held high, required 0", late_busy);
    end
    start = 1'b0;
    repeat (2) @(negedge clock_100Mhz);
    n_checks++;
    if (product !== 8'd42 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ignored_hold: product=%0d busy=%b, required 42/0", product, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] exp;
    logic       no_done;
    a = 4'd9;
    b = 4'd9;
    start = 1'b1;
    @(negedge clock_100Mhz);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_run: busy=%b, required 1", busy);
    end
    @(negedge clock_100Mhz);
    reset = 1'b1;
    @(negedge clock_100Mhz);
    reset = 1'b0;
    n_checks++;
    if (product !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_state: product=%0d busy=%b done=%b, required 0/0/0", product, busy, done);
    end
    no_done = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock_100Mhz);
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    n_checks++;
    if (no_done !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_no_done: activity=%b after abort, required 0", ~no_done);
    end
    start = 1'b1;
    exp_q.push_back(8'd81);
    repeat (5) begin
      @(negedge clock_100Mhz);
      start = 1'b0;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'bx;
    n_checks++;
    if (done !== 1'b1 || product !== exp) begin
      n_errors++;
      $display("FAIL midreset_rerun: done=%b product=%0d, required done=1 product=%0d", done, product, exp);
    end
  endtask

  task automatic test_width8();
    logic [15:0] exp;
    @(negedge clock_100Mhz);
    a8 = 8'd255;
    b8 = 8'd255;
    start8 = 1'b1;
    exp8_q.push_back(16'd65025);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock_100Mhz);
      start8 = 1'b0;
      n_checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
        n_errors++;
        $display("FAIL w8_busy cycle %0d: busy=%b done=%b, required 1/0", k, busy8, done8);
      end
    end
    @(negedge clock_100Mhz);
    exp = (exp8_q.size() > 0) ? exp8_q.pop_front() : 16'bx;
    n_checks++;
    if (done8 !== 1'b1 || product8 !== exp) begin
      n_errors++;
      $display("FAIL w8_result: done=%b product=%0d, required done=1 product=%0d", done8, product8, exp);
    end
    @(negedge clock_100Mhz);
    n_checks++;
    if (done8 !== 1'b0 || product8 !== 16'd65025) begin
      n_errors++;
      $display("FAIL w8_after: done=%b product=%0d, required 0/65025", done8, product8);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    a      = 4'd0;
    b      = 4'd0;
    start8 = 1'b0;
    a8     = 8'd0;
    b8     = 8'd0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignored_inputs();
    test_reset_mid_run();
    test_width8();
    n_checks++;
    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", exp_q.size(), exp8_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
